// File: rtl/shifter_seq_if.sv
// ----------------------------------------------------------------------------
// shifter_seq_if
//   Bundle of the command and result handshakes of shifter_seq.
//
//   in_valid / in_ready   command handshake (operand, mode, amount)
//   in_data               operand, NBITS wide
//   in_mode               000 PASS, 001 SRA, 010 SLL, 011 SRL, 100 ROL,
//                         101 ROR, 110/111 PASS
//   in_amt                shift amount, AMT_W wide
//   out_valid / out_ready result handshake
//   out_data              result, NBITS wide
//   busy                  shifter is working on or holding a command
//
//   Modports: slave is the shifter side, master is the producer/consumer side.
// ----------------------------------------------------------------------------
interface shifter_seq_if #(
    parameter int NBITS = 32
);
    localparam int AMT_W = $clog2(NBITS);

    logic             in_valid;
    logic             in_ready;
    logic [NBITS-1:0] in_data;
    logic [2:0]       in_mode;
    logic [AMT_W-1:0] in_amt;
    logic             out_valid;
    logic             out_ready;
    logic [NBITS-1:0] out_data;
    logic             busy;

    modport slave (
        input  in_valid,
        input  in_data,
        input  in_mode,
        input  in_amt,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data,
        output busy
    );

    modport master (
        output in_valid,
        output in_data,
        output in_mode,
        output in_amt,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data,
        input  busy
    );
endinterface

// File: rtl/shifter_seq.sv
// ----------------------------------------------------------------------------
// shifter_seq
//   Multi-cycle shifter. It accepts one operand per command handshake and
//   performs logical, arithmetic or rotate shifts by a variable amount. It moves
//   the operand at most STEP bits per clock, so wide shifts cost latency rather
//   than a full barrel shifter. The result is held until the consumer takes it.
//
//   Ports:
//     clk    rising-edge clock
//     reset  synchronous, active-high reset; aborts any command in flight
//     bus    shifter_seq_if.slave (command in, result out, busy)
//
//   Parameters:
//     NBITS  operand/result width (>= 2)
//     STEP   maximum bits shifted per clock (1 .. NBITS-1)
// ----------------------------------------------------------------------------
module shifter_seq #(
    parameter  int NBITS = 32,
    parameter  int STEP  = 1,
    localparam int AMT_W = $clog2(NBITS)
) (
    input  logic          clk,
    input  logic          reset,
    shifter_seq_if.slave  bus
);

    localparam logic [2:0] MODE_SRA = 3'b001;
    localparam logic [2:0] MODE_SLL = 3'b010;
    localparam logic [2:0] MODE_SRL = 3'b011;
    localparam logic [2:0] MODE_ROL = 3'b100;
    localparam logic [2:0] MODE_ROR = 3'b101;

    localparam logic [AMT_W-1:0] STEP_AMT = AMT_W'(STEP);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t           state_q,  state_d;
    logic [NBITS-1:0] work_q,   work_d;
    logic [2:0]       mode_q,   mode_d;
    logic [AMT_W-1:0] remain_q, remain_d;

    logic [AMT_W-1:0] stepAmt;
    logic [NBITS-1:0] stepResult;

    // Modes 000, 110 and 111 leave the operand untouched.
    function automatic logic isPass(input logic [2:0] m);
        return (m == 3'b000) || (m >= 3'b110);
    endfunction

    // One partial shift of the work value by k bits. Applying this repeatedly
    // with amounts summing to n gives the same result as one shift by n; for
    // SRA the sign bit of the current value is replicated, which preserves it.
    function automatic logic [NBITS-1:0] shiftStep(
        input logic [NBITS-1:0] w,
        input logic [2:0]       m,
        input logic [AMT_W-1:0] k
    );
        logic [31:0]      kk;
        logic [NBITS-1:0] r;
        kk = 32'(k);
        unique case (m)
            MODE_SRA: r = $signed(w) >>> kk;
            MODE_SLL: r = w << kk;
            MODE_SRL: r = w >> kk;
            MODE_ROL: r = (w << kk) | (w >> (32'(NBITS) - kk));
            MODE_ROR: r = (w >> kk) | (w << (32'(NBITS) - kk));
            default:  r = w;
        endcase
        return r;
    endfunction

    // Each SHIFT cycle moves min(STEP, remaining) bits.
    always_comb begin
        stepAmt    = (remain_q < STEP_AMT) ? remain_q : STEP_AMT;
        stepResult = shiftStep(work_q, mode_q, stepAmt);
    end

    // Next-state logic. Commands are only looked at in IDLE; a zero amount or
    // a pass mode skips SHIFT entirely.
    always_comb begin
        state_d  = state_q;
        work_d   = work_q;
        mode_d   = mode_q;
        remain_d = remain_q;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    work_d   = bus.in_data;
                    mode_d   = bus.in_mode;
                    remain_d = bus.in_amt;
                    if ((bus.in_amt == '0) || isPass(bus.in_mode)) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_SHIFT;
                    end
                end
            end
            ST_SHIFT: begin
                work_d   = stepResult;
                remain_d = remain_q - stepAmt;
                if (remain_q == stepAmt) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (bus.out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers. The work register doubles as the output register, so
    // clearing it on reset is what makes out_data read zero after reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            work_q   <= '0;
            mode_q   <= '0;
            remain_q <= '0;
        end else begin
            state_q  <= state_d;
            work_q   <= work_d;
            mode_q   <= mode_d;
            remain_q <= remain_d;
        end
    end

    assign bus.in_ready  = (state_q == ST_IDLE);
    assign bus.out_valid = (state_q == ST_DONE);
    assign bus.out_data  = work_q;
    assign bus.busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_shifter_seq.sv
// ----------------------------------------------------------------------------
// tb_shifter_seq
//   Drives two shifter_seq instances (STEP=1 and STEP=8, NBITS=32) with
//   directed commands. Expected results and latencies are queued when a command
//   is accepted; a monitor per instance compares them when results appear.
// ----------------------------------------------------------------------------
module tb_shifter_seq;

    localparam int NB = 32;

    localparam logic [2:0] M_PASS = 3'b000;
    localparam logic [2:0] M_SRA  = 3'b001;
    localparam logic [2:0] M_SLL  = 3'b010;
    localparam logic [2:0] M_SRL  = 3'b011;
    localparam logic [2:0] M_ROL  = 3'b100;
    localparam logic [2:0] M_ROR  = 3'b101;

    typedef struct {
        logic [31:0] data;
        int          acc;
        int          lat;
    } exp_t;

    logic clk = 1'b0;
    logic reset1;
    logic reset8;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    logic prev1 = 1'b0;
    logic prev8 = 1'b0;
    exp_t q1[$];
    exp_t q8[$];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    shifter_seq_if #(.NBITS(NB)) bus1 ();
    shifter_seq_if #(.NBITS(NB)) bus8 ();

    shifter_seq #(.NBITS(NB), .STEP(1)) dut1 (
        .clk   (clk),
        .reset (reset1),
        .bus   (bus1)
    );

    shifter_seq #(.NBITS(NB), .STEP(8)) dut8 (
        .clk   (clk),
        .reset (reset8),
        .bus   (bus8)
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("[TB] FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Issue one command and queue its expected result. acc is the cycle count
    // just before the acceptance edge, so latency 1 means valid right after it.
    task automatic applyStimulus(input int sel, input logic [2:0] mode, input logic [31:0] data,
                                 input logic [4:0] amt, input logic [31:0] expData, input int expLat);
        exp_t e;
        logic rdy;
        bit   done;
        done   = 1'b0;
        e.data = expData;
        e.lat  = expLat;
        if (sel == 1) begin
            bus1.in_valid = 1'b1; bus1.in_mode = mode; bus1.in_data = data; bus1.in_amt = amt;
        end else begin
            bus8.in_valid = 1'b1; bus8.in_mode = mode; bus8.in_data = data; bus8.in_amt = amt;
        end
        for (int i = 0; i < 100 && !done; i++) begin
            rdy   = (sel == 1) ? bus1.in_ready : bus8.in_ready;
            e.acc = cyc;
            @(posedge clk); #1;
            if (rdy) begin
                done = 1'b1;
                if (sel == 1) q1.push_back(e); else q8.push_back(e);
            end
        end
        if (sel == 1) bus1.in_valid = 1'b0; else bus8.in_valid = 1'b0;
        if (!done) checkOutput("accept timeout", 32'd0, 32'd1);
    endtask

    task automatic waitDrain(input int sel);
        bit done;
        done = 1'b0;
        for (int i = 0; i < 300 && !done; i++) begin
            @(negedge clk);
            if (sel == 1) done = (q1.size() == 0) && !bus1.out_valid;
            else          done = (q8.size() == 0) && !bus8.out_valid;
        end
        if (!done) checkOutput("drain timeout", 32'd0, 32'd1);
    endtask

    // Monitor for the STEP=1 instance.
    always @(negedge clk) begin
        if (reset1) begin
            prev1 = 1'b0;
        end else begin
            if (bus1.out_valid && !prev1) begin
                if (q1.size() == 0) begin
                    checkOutput("s1 unexpected result", 32'd1, 32'd0);
                end else begin
                    checkOutput("s1 data", bus1.out_data, q1[0].data);
                    checkOutput("s1 latency", 32'(cyc - q1[0].acc), 32'(q1[0].lat));
                end
            end
            if (bus1.out_valid && bus1.out_ready && q1.size() > 0) begin
                checkOutput("s1 data at transfer", bus1.out_data, q1[0].data);
                void'(q1.pop_front());
            end
            prev1 = bus1.out_valid;
        end
    end

    // Monitor for the STEP=8 instance.
    always @(negedge clk) begin
        if (reset8) begin
            prev8 = 1'b0;
        end else begin
            if (bus8.out_valid && !prev8) begin
                if (q8.size() == 0) begin
                    checkOutput("s8 unexpected result", 32'd1, 32'd0);
                end else begin
                    checkOutput("s8 data", bus8.out_data, q8[0].data);
                    checkOutput("s8 latency", 32'(cyc - q8[0].acc), 32'(q8[0].lat));
                end
            end
            if (bus8.out_valid && bus8.out_ready && q8.size() > 0) begin
                checkOutput("s8 data at transfer", bus8.out_data, q8[0].data);
                void'(q8.pop_front());
            end
            prev8 = bus8.out_valid;
        end
    end

    initial begin
        bit seen;
        reset1 = 1'b1; reset8 = 1'b1;
        bus1.in_valid = 1'b0; bus1.in_data = '0; bus1.in_mode = '0; bus1.in_amt = '0; bus1.out_ready = 1'b1;
        bus8.in_valid = 1'b0; bus8.in_data = '0; bus8.in_mode = '0; bus8.in_amt = '0; bus8.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset in_ready", 32'(bus1.in_ready), 32'd1);
        checkOutput("reset out_valid", 32'(bus1.out_valid), 32'd0);
        checkOutput("reset busy", 32'(bus1.busy), 32'd0);
        checkOutput("reset out_data", bus1.out_data, 32'h0);
        checkOutput("reset8 in_ready", 32'(bus8.in_ready), 32'd1);
        checkOutput("reset8 out_data", bus8.out_data, 32'h0);
        reset1 = 1'b0; reset8 = 1'b0;
        @(posedge clk); #1;

        // STEP=1: arithmetic, rotate, logical and pass cases.
        applyStimulus(1, M_SRA, 32'h8000_0010, 5'd4,  32'hF800_0001, 5);  waitDrain(1);
        applyStimulus(1, M_SRA, 32'h7FFF_FFF0, 5'd4,  32'h07FF_FFFF, 5);  waitDrain(1);
        applyStimulus(1, M_ROL, 32'h8000_0001, 5'd31, 32'hC000_0000, 32); waitDrain(1);
        applyStimulus(1, M_ROR, 32'h8000_0001, 5'd1,  32'hC000_0000, 2);  waitDrain(1);
        applyStimulus(1, M_SRL, 32'hFFFF_FFFF, 5'd31, 32'h0000_0001, 32); waitDrain(1);
        applyStimulus(1, M_PASS, 32'h1234_5678, 5'd5, 32'h1234_5678, 1);  waitDrain(1);
        applyStimulus(1, M_SLL, 32'h1234_5678, 5'd0,  32'h1234_5678, 1);  waitDrain(1);
        applyStimulus(1, 3'b111, 32'h1234_5678, 5'd7, 32'h1234_5678, 1);  waitDrain(1);
        applyStimulus(1, 3'b110, 32'h1234_5678, 5'd3, 32'h1234_5678, 1);  waitDrain(1);

        // STEP=8: partial last step, multi-step rotates and sign fill.
        applyStimulus(8, M_SLL, 32'h0000_00AB, 5'd8,  32'h0000_AB00, 2);  waitDrain(8);
        applyStimulus(8, M_SLL, 32'h0000_00AB, 5'd13, 32'h0015_6000, 3);  waitDrain(8);
        applyStimulus(8, M_ROL, 32'h8000_0001, 5'd31, 32'hC000_0000, 5);  waitDrain(8);
        applyStimulus(8, M_ROR, 32'h8000_0001, 5'd1,  32'hC000_0000, 2);  waitDrain(8);
        applyStimulus(8, M_SRL, 32'hFFFF_FFFF, 5'd31, 32'h0000_0001, 5);  waitDrain(8);
        applyStimulus(8, M_SRA, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF, 5);  waitDrain(8);
        // Back-to-back commands.
        applyStimulus(8, M_SRL, 32'h8000_0000, 5'd9,  32'h0040_0000, 3);
        applyStimulus(8, M_ROR, 32'h1234_5678, 5'd12, 32'h6781_2345, 3);  waitDrain(8);

        // Backpressure: result held while out_ready is low; inputs ignored.
        bus8.out_ready = 1'b0;
        applyStimulus(8, M_SLL, 32'h0000_0001, 5'd4, 32'h0000_0010, 2);
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            if (bus8.out_valid) seen = 1'b1;
            else begin @(posedge clk); #1; end
        end
        checkOutput("bp out_valid seen", 32'(seen), 32'd1);
        for (int i = 0; i < 10; i++) begin
            bus8.in_valid = i[0];
            bus8.in_data  = $urandom;
            bus8.in_mode  = M_PASS;
            bus8.in_amt   = 5'd0;
            @(negedge clk);
            checkOutput("bp out_data stable", bus8.out_data, 32'h0000_0010);
            checkOutput("bp in_ready low", 32'(bus8.in_ready), 32'd0);
            checkOutput("bp out_valid held", 32'(bus8.out_valid), 32'd1);
            @(posedge clk); #1;
        end
        bus8.in_valid  = 1'b0;
        bus8.out_ready = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        checkOutput("bp out_valid dropped", 32'(bus8.out_valid), 32'd0);
        checkOutput("bp idle in_ready", 32'(bus8.in_ready), 32'd1);
        checkOutput("bp idle busy", 32'(bus8.busy), 32'd0);
        checkOutput("bp out_data retained", bus8.out_data, 32'h0000_0010);
        repeat (3) @(negedge clk);
        checkOutput("bp no extra result", 32'(bus8.out_valid), 32'd0);
        checkOutput("bp queue empty", 32'(q8.size()), 32'd0);

        // Reset in the middle of a long shift.
        @(posedge clk); #1;
        applyStimulus(1, M_SLL, 32'h0000_0001, 5'd20, 32'h0010_0000, 21);
        repeat (4) @(posedge clk);
        #1;
        checkOutput("mid-shift busy", 32'(bus1.busy), 32'd1);
        reset1 = 1'b1;
        q1.delete();
        @(posedge clk); #1;
        reset1 = 1'b0;
        @(negedge clk);
        checkOutput("abort in_ready", 32'(bus1.in_ready), 32'd1);
        checkOutput("abort out_valid", 32'(bus1.out_valid), 32'd0);
        checkOutput("abort out_data", bus1.out_data, 32'h0);
        checkOutput("abort busy", 32'(bus1.busy), 32'd0);
        @(posedge clk); #1;
        applyStimulus(1, M_SRL, 32'h0000_00F0, 5'd4, 32'h0000_000F, 5);   waitDrain(1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
